program_load_sequencer: RTL

//  Sequences the instruction memory between the host program loader and CPU fetch.
//  In load phases it accepts program words over a valid/ready stream and writes them
//  to consecutive instruction addresses while the CPU is held.
//  In run phases it hands the memory address port to the CPU fetch PC.
//  It releases the CPU at a chosen entry address, and re-arms on CPU halt.

---
 rtl/program_load_sequencer.sv | 193 +++++++++++++++++++
 1 files changed

// File: rtl/program_load_sequencer.sv
// Instruction-memory sequencer: streams host program words into consecutive
// addresses while the CPU is held, then releases the CPU at an entry PC.
module program_load_sequencer #(
  parameter int unsigned AW    = 10,
  parameter int unsigned DW    = 32,
  parameter int unsigned DEPTH = 1024
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_load_start,
  input  logic [AW-1:0] i_load_base,
  input  logic [AW:0]   i_load_count,
  input  logic          i_in_valid,
  input  logic [DW-1:0] i_in_data,
  output logic          o_in_ready,
  input  logic          i_run_start,
  input  logic [AW-1:0] i_run_addr,
  input  logic [AW-1:0] i_cpu_pc,
  input  logic          i_cpu_halt,
  output logic          o_cpu_hold,
  output logic          o_pc_load,
  output logic [AW-1:0] o_pc_value,
  output logic [AW-1:0] o_ram_addr,
  output logic          o_ram_we,
  output logic [DW-1:0] o_ram_wdata,
  output logic          o_load_done,
  output logic          o_load_err
);

  localparam int unsigned CW = AW + 1;
  localparam logic [CW-1:0] LAST_ADDR = CW'(DEPTH - 1);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_LOAD = 3'd1;
  localparam logic [2:0] S_DONE = 3'd2;
  localparam logic [2:0] S_RUN  = 3'd3;
  localparam logic [2:0] S_HALT = 3'd4;

  logic [2:0]    r_state;
  logic [AW-1:0] r_base;
  logic [CW-1:0] r_count;
  logic [CW-1:0] r_idx;
  logic [AW-1:0] r_waddr;
  logic [DW-1:0] r_wdata;
  logic          r_we;
  logic          r_in_ready;
  logic          r_cpu_hold;
  logic          r_pc_load;
  logic [AW-1:0] r_pc_value;
  logic          r_load_done;
  logic          r_load_err;

  logic [2:0]    w_state_nxt;
  logic [AW-1:0] w_base_nxt;
  logic [CW-1:0] w_count_nxt;
  logic [CW-1:0] w_idx_nxt;
  logic [AW-1:0] w_waddr_nxt;
  logic [DW-1:0] w_wdata_nxt;
  logic          w_we_nxt;
  logic          w_in_ready_nxt;
  logic          w_cpu_hold_nxt;
  logic          w_pc_load_nxt;
  logic [AW-1:0] w_pc_value_nxt;
  logic          w_load_done_nxt;
  logic          w_load_err_nxt;

  logic          w_xfer;
  logic [CW-1:0] w_sum;
  logic          w_overrun;
  logic [CW-1:0] w_idx_inc;
  logic          w_last;

  // Handshake and target address of the word being offered this cycle.
  assign w_xfer    = (r_state == S_LOAD) && r_in_ready && i_in_valid;
  assign w_sum     = CW'(r_base) + r_idx;
  assign w_overrun = (w_sum > LAST_ADDR);
  assign w_idx_inc = r_idx + CW'(1);
  assign w_last    = (w_idx_inc == r_count);

  // State register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    w_state_nxt    = r_state;
    w_base_nxt     = r_base;
    w_count_nxt    = r_count;
    w_idx_nxt      = r_idx;
    w_waddr_nxt    = r_waddr;
    w_wdata_nxt    = r_wdata;
    w_we_nxt       = 1'b0;
    w_pc_load_nxt  = 1'b0;
    w_pc_value_nxt = r_pc_value;
    w_load_err_nxt = r_load_err;

    case (r_state)
      S_IDLE, S_HALT: begin
        if (i_load_start) begin
          w_base_nxt     = i_load_base;
          w_count_nxt    = i_load_count;
          w_idx_nxt      = '0;
          w_load_err_nxt = 1'b0;
          w_state_nxt    = (i_load_count == '0) ? S_DONE : S_LOAD;
        end else if (i_run_start) begin
          w_pc_value_nxt = i_run_addr;
          w_pc_load_nxt  = 1'b1;
          w_state_nxt    = S_RUN;
        end
      end
      S_LOAD: begin
        if (w_xfer) begin
          if (w_overrun) begin
            w_load_err_nxt = 1'b1;
            w_state_nxt    = S_DONE;
          end else begin
            w_we_nxt    = 1'b1;
            w_waddr_nxt = w_sum[AW-1:0];
            w_wdata_nxt = i_in_data;
            w_idx_nxt   = w_idx_inc;
            if (w_last) begin
              w_state_nxt = S_DONE;
            end
          end
        end
      end
      S_DONE: begin
        w_state_nxt = S_HALT;
      end
      S_RUN: begin
        if (i_cpu_halt) begin
          w_state_nxt = S_HALT;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase

    // CPU runs only while the previous and next cycle are both RUN.
    w_in_ready_nxt  = (w_state_nxt == S_LOAD);
    w_cpu_hold_nxt  = !((r_state == S_RUN) && (w_state_nxt == S_RUN));
    w_load_done_nxt = (w_state_nxt == S_DONE) && (r_state != S_DONE) && !w_load_err_nxt;
  end

  // Registered datapath and outputs.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_base      <= '0;
      r_count     <= '0;
      r_idx       <= '0;
      r_waddr     <= '0;
      r_wdata     <= '0;
      r_we        <= 1'b0;
      r_in_ready  <= 1'b0;
      r_cpu_hold  <= 1'b1;
      r_pc_load   <= 1'b0;
      r_pc_value  <= '0;
      r_load_done <= 1'b0;
      r_load_err  <= 1'b0;
    end else begin
      r_base      <= w_base_nxt;
      r_count     <= w_count_nxt;
      r_idx       <= w_idx_nxt;
      r_waddr     <= w_waddr_nxt;
      r_wdata     <= w_wdata_nxt;
      r_we        <= w_we_nxt;
      r_in_ready  <= w_in_ready_nxt;
      r_cpu_hold  <= w_cpu_hold_nxt;
      r_pc_load   <= w_pc_load_nxt;
      r_pc_value  <= w_pc_value_nxt;
      r_load_done <= w_load_done_nxt;
      r_load_err  <= w_load_err_nxt;
    end
  end

  // Memory port belongs to the loader in LOAD/DONE, to CPU fetch otherwise.
  assign o_ram_addr  = ((r_state == S_LOAD) || (r_state == S_DONE)) ? r_waddr : i_cpu_pc;
  assign o_ram_we    = r_we;
  assign o_ram_wdata = r_wdata;
  assign o_in_ready  = r_in_ready;
  assign o_cpu_hold  = r_cpu_hold;
  assign o_pc_load   = r_pc_load;
  assign o_pc_value  = r_pc_value;
  assign o_load_done = r_load_done;
  assign o_load_err  = r_load_err;

endmodule
